// File: rtl/fifo_ptr_mem_if.sv
// Handshake/data bundle between the FIFO pointer/storage block and its status block.
// slave = fifo_ptr_mem side, master = environment/status side.
interface fifo_ptr_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_we;
  logic              fifo_rd;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   level;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;

  modport slave (
    input  wr, rd, data_in, fifo_full, fifo_empty,
    output fifo_we, fifo_rd, wptr, rptr, level, data_out, data_valid
  );

  modport master (
    output wr, rd, data_in, fifo_full, fifo_empty,
    input  fifo_we, fifo_rd, wptr, rptr, level, data_out, data_valid
  );
endinterface

// File: rtl/fifo_ptr_mem.sv
// Write/read pointers and 2^ADDR_W x DATA_W storage for the synchronous FIFO.
// Define FIFO_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module fifo_ptr_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_ptr_mem_if.slave bus
);

`ifdef FIFO_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic                          w_we;
  logic                          w_rd;
  logic [ADDR_W:0]               r_wptr;
  logic [ADDR_W:0]               r_rptr;
  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [STAGES:1]               r_vld_pipe;
  logic [STAGES:1][DATA_W-1:0]   r_dat_pipe;

  // Qualification uses the status block's flags directly; no local flag copies.
  assign w_we = bus.wr & ~bus.fifo_full;
  assign w_rd = bus.rd & ~bus.fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage is intentionally not reset; pointer reset hides stale words.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr[ADDR_W-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_dat_pipe[1] <= '0;
    end else begin
      r_vld_pipe[1] <= w_rd;
      if (w_rd) r_dat_pipe[1] <= r_mem[r_rptr[ADDR_W-1:0]];
    end
  end

  for (genvar s = 2; s <= STAGES; s++) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_pipe[s] <= 1'b0;
        r_dat_pipe[s] <= '0;
      end else begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign bus.fifo_we    = w_we;
  assign bus.fifo_rd    = w_rd;
  assign bus.wptr       = r_wptr;
  assign bus.rptr       = r_rptr;
  assign bus.level      = r_wptr - r_rptr;
  assign bus.data_out   = r_dat_pipe[STAGES];
  assign bus.data_valid = r_vld_pipe[STAGES];

endmodule
